mem_access_ctrl: RTL and testbench

//  CPU-side initiator for the single-port block-RAM data memory (8-bit addr, 16-bit data).

---
 rtl/mem_if_pkg.sv | 19 +
 rtl/mem_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// ---------------------------------------------------------------------------
// mem_if_pkg
//   Shared definitions for the data-memory interface: the controller state
//   encoding and default RAM geometry/latency. The RAM wrapper, the control
//   unit and mem_access_ctrl all import this package.
// ---------------------------------------------------------------------------
package mem_if_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_RD_LAT = 2;   // legal range 1..7 (3-bit latency counter)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } mem_state_e;

endpackage : mem_if_pkg

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   CPU-side initiator for the single-port block-RAM data memory. Takes one
//   read or write request per transaction, drives the RAM pins from
//   registers, times the RAM read latency and returns a one-cycle response.
//
// Ports
//   clk        in   1       system clock, all logic on posedge
//   rst        in   1       synchronous active-high reset
//   req_valid  in   1       request present
//   req_ready  out  1       request can be accepted this cycle
//   req_we     in   1       1 = write, 0 = read
//   req_addr   in   ADDR_W  request address
//   req_wdata  in   DATA_W  write data (ignored on read)
//   rsp_valid  out  1       one-cycle pulse: read data valid / write done
//   rsp_rdata  out  DATA_W  last read data, held until the next read completes
//   busy       out  1       transaction in flight
//   mem_en     out  1       RAM enable
//   mem_we     out  1       RAM write enable
//   mem_addr   out  ADDR_W  RAM address
//   mem_din    out  DATA_W  RAM write data
//   mem_dout   in   DATA_W  RAM read data
//   dbg_state  out  2       current FSM state (debug observation only)
//
// Handshake: a request transfers on a posedge where req_valid && req_ready.
// req_ready is high only in IDLE and never while rst is asserted; the
// requester must hold req_valid and its payload until the transfer.
// rsp_valid has no backpressure.
// ---------------------------------------------------------------------------
module mem_access_ctrl
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int RD_LAT = MEM_RD_LAT   // 1..7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output mem_state_e        dbg_state
);

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  mem_state_e        state_q,     state_d;
  logic [2:0]        lat_cnt_q,   lat_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_din_q,   mem_din_d;

  logic accept;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;

    unique case (state_q)
      IDLE: begin
        // The mem_addr/mem_din registers double as the captured request, so
        // later wiggles on req_* cannot reach the RAM pins.
        if (accept) begin
          mem_addr_d = req_addr;
          if (req_we) begin
            state_d   = WRITE;
            mem_din_d = req_wdata;
          end else begin
            state_d   = READ;
            lat_cnt_d = 3'd1;
          end
        end
      end
      WRITE: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
      end
      READ: begin
        // lat_cnt equals the number of cycles the address has been on the
        // RAM pins; at RD_LAT the RAM output is valid and gets captured.
        if (lat_cnt_q == RD_LAT_C) begin
          state_d     = IDLE;
          lat_cnt_d   = 3'd0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_dout;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        lat_cnt_d = 3'd0;
      end
    endcase

    // RAM strobes are derived from the next state so they are registered
    // and line up exactly with the WRITE/READ cycles.
    mem_en_d = (state_d != IDLE);
    mem_we_d = (state_d == WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != IDLE);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign dbg_state = state_q;

endmodule : mem_access_ctrl

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl with a behavioural RAM, a
//   transaction-level reference model checked every cycle, and literal
//   expectations for the headline scenarios.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;
  import mem_if_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;   // number of posedges seen
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, busy, mem_en, mem_we;
  logic [DW-1:0] rsp_rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  mem_state_e    dbg_state;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .dbg_state (dbg_state)
  );

  // ---------------- behavioural RAM (environment) ----------------
  // One registered output stage: address seen at the end of the first
  // enabled cycle, data valid during the second, matching RD_LAT=2.
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        mem_dout      <= ram[mem_addr];
    end
  end

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the one outstanding transaction by its age (cycles since the
  // accepting edge) and derives every output from the timing rules.
  logic          m_active   = 1'b0;
  logic          m_we       = 1'b0;
  logic [AW-1:0] m_addr     = '0;
  logic [DW-1:0] m_data     = '0;
  logic [DW-1:0] m_rdata    = '0;
  int            m_age      = 0;
  logic          m_last_rst = 1'b1;
  logic [DW-1:0] ref_mem [0:255];

  always @(negedge clk) begin : model
    logic e_en, e_we, e_rsp, e_busy, e_ready;
    int   span;
    span = m_we ? 1 : LAT;
    if (cyc > 0) begin
      e_en = 1'b0; e_we = 1'b0; e_rsp = 1'b0; e_busy = 1'b0;
      if (m_last_rst) begin
        m_rdata = '0;
      end else if (m_active) begin
        if (m_age <= span) begin
          e_busy = 1'b1; e_en = 1'b1; e_we = m_we;
        end else if (m_age == span + 1) begin
          e_rsp = 1'b1;
          if (!m_we) m_rdata = ref_mem[m_addr];
        end
      end
      e_ready = !e_busy && !rst;

      check("m_req_ready", 32'(req_ready), 32'(e_ready));
      check("m_busy",      32'(busy),      32'(e_busy));
      check("m_rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      check("m_mem_en",    32'(mem_en),    32'(e_en));
      check("m_mem_we",    32'(mem_we),    32'(e_we));
      check("m_rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      if (e_en) check("m_mem_addr", 32'(mem_addr), 32'(m_addr));
      if (e_we) check("m_mem_din",  32'(mem_din),  32'(m_data));
      if (m_last_rst) begin
        check("m_rst_addr", 32'(mem_addr), 32'h0);
        check("m_rst_din",  32'(mem_din),  32'h0);
      end

      // Plan the next edge. A write strobed this cycle lands in RAM even
      // if reset hits at the edge.
      if (e_we) ref_mem[m_addr] = m_data;
      if (rst) begin
        m_active   = 1'b0;
        m_last_rst = 1'b1;
      end else begin
        m_last_rst = 1'b0;
        if (e_ready && req_valid) begin
          m_active = 1'b1; m_we = req_we; m_addr = req_addr;
          m_data = req_wdata; m_age = 1;
        end else if (m_active) begin
          m_age++;
          if (m_age > span + 1) m_active = 1'b0;
        end
      end
    end else begin
      m_last_rst = rst;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at posedge+#1 after the accepting edge,
  // with acc = index of that edge. req_valid is left high.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int acc);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no accept expected accept within 20 cycles (cycle %0d)", cyc);
    end
  endtask

  // Returns the edge index that raised rsp_valid and the data seen.
  task automatic wait_rsp(output int at, output logic [DW-1:0] data);
    at = -1; data = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        at = cyc; data = rsp_rdata;
        break;
      end
    end
    if (at < 0) begin
      tests++; fails++;
      $display("FAIL rsp_timeout: got no rsp_valid expected rsp_valid within 20 cycles (cycle %0d)", cyc);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  int            a0, a1, a2, at, cnt;
  logic [DW-1:0] d;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0; ref_mem[i] = '0;
    end
    mem_dout = '0;

    // Reset held 3 edges with a request pending: nothing may be accepted.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h55; req_wdata = 16'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_low", 32'(req_ready), 32'h0);
    check("rst_mem_en",    32'(mem_en),    32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("rst_ready_high", 32'(req_ready), 32'h1);
    check("rst_busy",       32'(busy),      32'h0);
    check("rst_rdata",      32'(rsp_rdata), 32'h0);
    @(posedge clk); #1;

    // Write 0xA5A5 to 0x10, then scramble req_* after the accept.
    send(1'b1, 8'h10, 16'hA5A5, a0);
    req_valid = 1'b0; req_addr = 8'h77; req_wdata = 16'hDEAD;
    @(negedge clk);
    check("wr_mem_we",   32'(mem_we),   32'h1);
    check("wr_mem_addr", 32'(mem_addr), 32'h10);
    check("wr_mem_din",  32'(mem_din),  32'hA5A5);
    wait_rsp(at, d);
    check("wr_rsp_lat", 32'(at - a0), 32'd1);

    // Read it back: address on the pins LAT cycles, response one after.
    send(1'b0, 8'h10, 16'h0, a0);
    req_valid = 1'b0;
    wait_rsp(at, d);
    check("rd_rsp_lat", 32'(at - a0), 32'd2);
    check("rd_data",    32'(d),       32'hA5A5);

    // Back-to-back with req_valid held: W(0x00), W(0xFF), R(0xFF).
    send(1'b1, 8'h00, 16'h1111, a0);
    send(1'b1, 8'hFF, 16'h2222, a1);
    send(1'b0, 8'hFF, 16'h0000, a2);
    req_valid = 1'b0;
    check("b2b_gap1", 32'(a1 - a0), 32'd2);
    check("b2b_gap2", 32'(a2 - a1), 32'd2);
    wait_rsp(at, d);
    check("b2b_rd_data", 32'(d), 32'h2222);

    // Reset one cycle into a read: aborted, no response, rdata cleared.
    send(1'b0, 8'h00, 16'h0, a0);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("abort_en_before", 32'(mem_en), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_mem_en", 32'(mem_en),    32'h0);
    check("abort_rdata",  32'(rsp_rdata), 32'h0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("abort_no_rsp", 32'(cnt), 32'h0);
    @(posedge clk); #1;

    // Write-then-read at a fresh address, wrap address reread, unwritten read.
    send(1'b1, 8'h33, 16'hBEEF, a0);
    send(1'b0, 8'h33, 16'h0, a1);
    req_valid = 1'b0;
    wait_rsp(at, d);
    check("wtr_data", 32'(d), 32'hBEEF);
    send(1'b0, 8'hFF, 16'h0, a0);
    req_valid = 1'b0;
    wait_rsp(at, d);
    check("ff_data", 32'(d), 32'h2222);
    send(1'b1, 8'h40, 16'h0F0F, a0);
    req_valid = 1'b0;
    wait_rsp(at, d);
    check("wr_keeps_rdata", 32'(rsp_rdata), 32'h2222);
    send(1'b0, 8'h80, 16'h0, a0);
    req_valid = 1'b0;
    wait_rsp(at, d);
    check("unwritten_data", 32'(d), 32'h0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule : tb_mem_access_ctrl
